// File: rtl/apu_i2s_tx.sv
// I2S (Philips) transmitter for the APU sample stream: divides clk_in down to BCLK/LRCK
// and shifts the same 16-bit sample out on both channels, with optional sign conversion,
// attenuation and mute.
//
// state | meaning
// IDLE  | serializer stopped, all outputs and counters held at 0
// RUN   | BCLK/LRCK generation and data shifting active
module apu_i2s_tx #(
  parameter int BCLK_HALF   = 16,
  parameter int SLOT_BITS   = 32,
  parameter bit SIGNED_CONV = 1'b1
) (
  input  logic        clk_in,
  input  logic        nres_in,
  input  logic        en_in,
  input  logic [15:0] sample_in,
  input  logic        mute_in,
  input  logic [2:0]  vol_in,
  output logic        bclk_out,
  output logic        lrck_out,
  output logic        sdata_out,
  output logic        sample_strobe_out
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] WORD_END = BIT_W'(16);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_nxt, bit_inc, slot_pos;
  logic [3:0]       bit_idx;
  logic [15:0]      hold, hold_nxt, conv, cap_word;
  logic             bclk_nxt, lrck_nxt, sdata_nxt, strobe_nxt;

  // Sign fill on the shift applies even when the input is left as offset binary.
  always_comb begin
    conv     = SIGNED_CONV ? {~sample_in[15], sample_in[14:0]} : sample_in;
    cap_word = mute_in ? 16'h0000 : 16'($signed(conv) >>> vol_in);
  end

  // Slot position of the bit about to go out; position 0 is the I2S one-BCLK delay.
  always_comb begin
    bit_inc  = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
    slot_pos = (bit_inc >= SLOT) ? bit_inc - SLOT : bit_inc;
    bit_idx  = 4'(5'd16 - 5'(slot_pos));
  end

  always_comb begin
    state_nxt  = state;
    div_nxt    = div_cnt;
    bit_nxt    = bit_cnt;
    hold_nxt   = hold;
    bclk_nxt   = bclk_out;
    lrck_nxt   = lrck_out;
    sdata_nxt  = sdata_out;
    strobe_nxt = 1'b0;
    case (state)
      IDLE: begin
        div_nxt   = '0;
        bit_nxt   = '0;
        bclk_nxt  = 1'b0;
        lrck_nxt  = 1'b0;
        sdata_nxt = 1'b0;
        if (en_in) begin
          state_nxt  = RUN;
          hold_nxt   = cap_word;
          strobe_nxt = 1'b1;
        end
      end
      RUN: begin
        if (!en_in) begin
          state_nxt = IDLE;
          div_nxt   = '0;
          bit_nxt   = '0;
          bclk_nxt  = 1'b0;
          lrck_nxt  = 1'b0;
          sdata_nxt = 1'b0;
        end else if (div_cnt == DIV_LAST) begin
          div_nxt  = '0;
          bclk_nxt = ~bclk_out;
          if (bclk_out) begin
            bit_nxt   = bit_inc;
            lrck_nxt  = (bit_inc >= SLOT);
            sdata_nxt = (slot_pos != '0 && slot_pos <= WORD_END) ? hold[bit_idx] : 1'b0;
            if (bit_inc == '0) begin
              hold_nxt   = cap_word;
              strobe_nxt = 1'b1;
            end
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge nres_in) begin
    if (!nres_in) begin
      state             <= IDLE;
      div_cnt           <= '0;
      bit_cnt           <= '0;
      hold              <= '0;
      bclk_out          <= 1'b0;
      lrck_out          <= 1'b0;
      sdata_out         <= 1'b0;
      sample_strobe_out <= 1'b0;
    end else begin
      state             <= state_nxt;
      div_cnt           <= div_nxt;
      bit_cnt           <= bit_nxt;
      hold              <= hold_nxt;
      bclk_out          <= bclk_nxt;
      lrck_out          <= lrck_nxt;
      sdata_out         <= sdata_nxt;
      sample_strobe_out <= strobe_nxt;
    end
  end

endmodule

// File: tb/tb_apu_i2s_tx.sv
// Self-checking bench for apu_i2s_tx: decodes the I2S stream frame by frame and compares
// it with words computed from the sample/mute/volume rules.
module tb_apu_i2s_tx;
  localparam int BH = 4;
  localparam int SB = 32;

  logic        clk_in = 1'b0;
  logic        nres_in, en_in, mute_in;
  logic [15:0] sample_in;
  logic [2:0]  vol_in;
  logic        bclk_out, lrck_out, sdata_out, sample_strobe_out;

  int n_pass = 0, n_total = 0, cyc = 0, mon_err = 0;
  logic [15:0] chg_sample = '0;
  logic [2:0]  chg_vol = '0;
  logic        chg_mute = 1'b0;

  typedef struct {
    logic [15:0] sample;
    logic        mute;
    logic [2:0]  vol;
    logic [15:0] word;
    string       nm;
  } vec_t;
  vec_t vecs[6];

  apu_i2s_tx #(.BCLK_HALF(BH), .SLOT_BITS(SB), .SIGNED_CONV(1'b1)) dut (
    .clk_in(clk_in), .nres_in(nres_in), .en_in(en_in), .sample_in(sample_in),
    .mute_in(mute_in), .vol_in(vol_in), .bclk_out(bclk_out), .lrck_out(lrck_out),
    .sdata_out(sdata_out), .sample_strobe_out(sample_strobe_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // While running, lrck/sdata may only move on a bclk fall.
  logic pb = 1'b0, pl = 1'b0, ps = 1'b0, pen = 1'b0, prn = 1'b0;
  always @(negedge clk_in) begin
    if (en_in && nres_in && pen && prn && (lrck_out !== pl || sdata_out !== ps) && !(pb && !bclk_out))
      mon_err <= mon_err + 1;
    pb  <= bclk_out;
    pl  <= lrck_out;
    ps  <= sdata_out;
    pen <= en_in;
    prn <= nres_in;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
  endtask

  // Offset binary -> signed, then floor division by 2^vol.
  function automatic logic [15:0] ref_word(input logic [15:0] smp, input logic mute, input logic [2:0] vol);
    int v, d;
    if (mute) return 16'h0000;
    v = int'(smp) - 32768;
    d = 1 << vol;
    if (v >= 0) v = v / d;
    else v = -((-v + d - 1) / d);
    return 16'(v);
  endfunction

  task automatic wait_strobe(input string nm, output int s0);
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!sample_strobe_out && n < 2000);
    if (!sample_strobe_out) chk({nm, "_strobe_timeout"}, 32'd0, 32'd1);
    s0 = cyc;
  endtask

  task automatic collect(input logic [15:0] exp, input string nm, input int chg_at);
    int s0, rises = 0, n = 0, lr_err = 0, stray = 0;
    logic prev;
    logic [15:0] lw = '0, rw = '0;
    wait_strobe(nm, s0);
    prev = bclk_out;
    while (rises < 2 * SB && n < 1200) begin
      @(negedge clk_in);
      n++;
      if (bclk_out && !prev) begin
        int p;
        p = rises % SB;
        if (lrck_out !== (rises >= SB)) lr_err++;
        if (p >= 1 && p <= 16) begin
          if (rises < SB) lw[16 - p] = sdata_out;
          else rw[16 - p] = sdata_out;
        end else if (sdata_out !== 1'b0) stray++;
        rises++;
        if (rises == chg_at) begin
          sample_in = chg_sample;
          vol_in    = chg_vol;
          mute_in   = chg_mute;
        end
      end
      prev = bclk_out;
    end
    chk({nm, "_rises"}, rises, 2 * SB);
    chk({nm, "_left"}, lw, exp);
    chk({nm, "_right"}, rw, exp);
    chk({nm, "_lrck_pattern_errs"}, lr_err, 0);
    chk({nm, "_stray_bits"}, stray, 0);
  endtask

  task automatic timing_check();
    int s0, rises = 0, n = 0, rise_err = 0, lr_rise = -1;
    logic prev, prevl;
    wait_strobe("tim", s0);
    prev  = bclk_out;
    prevl = lrck_out;
    do begin
      @(negedge clk_in);
      n++;
      if (bclk_out && !prev) begin
        if (cyc != s0 + BH + 2 * BH * rises) rise_err++;
        rises++;
      end
      if (lrck_out && !prevl) lr_rise = cyc - s0;
      prev  = bclk_out;
      prevl = lrck_out;
    end while (!sample_strobe_out && n < 1200);
    chk("tim_bclk_rises", rises, 2 * SB);
    chk("tim_bclk_period_errs", rise_err, 0);
    chk("tim_lrck_rise_offset", lr_rise, SB * 2 * BH);
    chk("tim_strobe_period", cyc - s0, 2 * SB * 2 * BH);
    chk("tim_lrck_at_strobe", lrck_out, 0);
  endtask

  initial begin
    int s0, s1, n, err;
    vecs[0] = '{16'h8000, 1'b0, 3'd0, 16'h0000, "conv_8000"};
    vecs[1] = '{16'hFFFF, 1'b0, 3'd0, 16'h7FFF, "conv_ffff"};
    vecs[2] = '{16'h0000, 1'b0, 3'd0, 16'h8000, "conv_0000"};
    vecs[3] = '{16'h0000, 1'b0, 3'd2, 16'hE000, "att_v2"};
    vecs[4] = '{16'hC000, 1'b0, 3'd7, 16'h0080, "att_v7"};
    vecs[5] = '{16'hFFFF, 1'b1, 3'd0, 16'h0000, "mute"};

    nres_in = 1'b0; en_in = 1'b0; sample_in = '0; mute_in = 1'b0; vol_in = '0;
    err = 0;
    repeat (5) begin
      @(negedge clk_in);
      if ({bclk_out, lrck_out, sdata_out, sample_strobe_out} !== 4'b0) err++;
    end
    chk("reset_outputs_nonzero", err, 0);
    nres_in = 1'b1;
    err = 0;
    repeat (1000) begin
      @(negedge clk_in);
      if ({bclk_out, lrck_out, sdata_out, sample_strobe_out} !== 4'b0) err++;
    end
    chk("idle_outputs_nonzero", err, 0);

    for (int i = 0; i < 6; i++) begin
      sample_in = vecs[i].sample;
      mute_in   = vecs[i].mute;
      vol_in    = vecs[i].vol;
      if (i == 0) en_in = 1'b1;
      collect(vecs[i].word, vecs[i].nm, 0);
    end

    timing_check();

    sample_in = 16'h1234; vol_in = 3'd0; mute_in = 1'b0;
    chg_sample = 16'hABCD; chg_vol = 3'd3; chg_mute = 1'b0;
    collect(ref_word(16'h1234, 1'b0, 3'd0), "mid_old", 20);
    collect(ref_word(16'hABCD, 1'b0, 3'd3), "mid_new", 0);

    for (int i = 0; i < 16; i++) begin
      sample_in = 16'($urandom);
      mute_in   = ($urandom_range(0, 7) == 0);
      vol_in    = 3'($urandom_range(0, 7));
      collect(ref_word(sample_in, mute_in, vol_in), $sformatf("rnd%0d", i), 0);
    end

    // Drop enable while bit_cnt = 40 (falls every 2*BH clk after capture).
    wait_strobe("drop", s0);
    n = 0;
    while (cyc < s0 + 40 * 2 * BH + 2 && n < 1000) begin
      @(negedge clk_in);
      n++;
    end
    chk("drop_pre_lrck", lrck_out, 1);
    en_in = 1'b0;
    @(negedge clk_in);
    chk("drop_outputs", {bclk_out, lrck_out, sdata_out, sample_strobe_out}, 0);
    err = 0;
    repeat (20) begin
      @(negedge clk_in);
      if ({bclk_out, lrck_out, sdata_out, sample_strobe_out} !== 4'b0) err++;
    end
    chk("drop_idle_nonzero", err, 0);
    sample_in = 16'h0000; vol_in = 3'd0; mute_in = 1'b0;
    en_in = 1'b1;
    @(negedge clk_in);
    chk("reen_strobe", sample_strobe_out, 1);
    s1 = cyc;
    repeat (2 * BH - 1) @(negedge clk_in);
    chk("reen_before_msb", sdata_out, 0);
    @(negedge clk_in);
    chk("reen_msb_lrck_sdata", {lrck_out, sdata_out}, 2'b01);

    while (cyc < s1 + 108) @(negedge clk_in);
    #1 nres_in = 1'b0;
    #1 chk("rst_async_outputs", {bclk_out, lrck_out, sdata_out, sample_strobe_out}, 0);
    repeat (3) @(negedge clk_in);
    nres_in = 1'b1;
    @(negedge clk_in);
    chk("rst_restart_strobe", sample_strobe_out, 1);
    repeat (2 * BH - 1) @(negedge clk_in);
    chk("rst_before_msb", sdata_out, 0);
    @(negedge clk_in);
    chk("rst_msb_lrck_sdata", {lrck_out, sdata_out}, 2'b01);
    collect(16'h8000, "rst_frame", 0);

    chk("edge_alignment_errs", mon_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
